video_frame_checker: RTL and testbench

//  Receive end of the video interface: sits on pixel_clk beside the vga controller's outputs (HS/VS/BLANK/RGB),

---
 rtl/video_frame_checker_pkg.sv | 14 +
 rtl/video_frame_checker_if.sv | 12 +
 rtl/video_frame_checker_line_meter.sv | 74 +++++++
 rtl/video_frame_checker.sv | 182 ++++++++++++++++++
 tb/tb_video_frame_checker.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_frame_checker_pkg.sv
// Shared types and defaults for the video frame checker.
// Optional checksum output is controlled by FRAME_CHECKER_CSUM_EN (see video_frame_checker).
package video_chk_pkg;

  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;
  localparam int LOCK_CNT_W = 4;

  typedef enum logic [0:0] {
    WAIT_VS = 1'b0,
    FRAME   = 1'b1
  } chk_state_e;

endpackage

// File: rtl/video_frame_checker_if.sv
// Raw video stream (sync, blank, pixel data) as seen on the pixel_clk domain.
interface video_frame_checker_if;

  logic        vid_hs;
  logic        vid_vs;
  logic        vid_blank;
  logic [23:0] vid_rgb;

  modport master (output vid_hs, output vid_vs, output vid_blank, output vid_rgb);
  modport slave  (input  vid_hs, input  vid_vs, input  vid_blank, input  vid_rgb);

endinterface

// File: rtl/video_frame_checker_line_meter.sv
// Per-frame line measurement: pixel counter, first-line width, sticky bad-width flag, line counter.
module video_line_meter
  import video_chk_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int HCNT_W = HCNT_W_DEF,
  parameter int VCNT_W = VCNT_W_DEF
) (
  input  logic              pixel_clk,
  input  logic              pixel_rst_n,
  input  logic              blank_s1,
  input  logic              blank_s2,
  input  logic              clear,
  output logic [HCNT_W-1:0] first_w,
  output logic [VCNT_W-1:0] line_cnt,
  output logic              hbad
);

  logic [HCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [HCNT_W-1:0] first_w_q, first_w_d;
  logic [VCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic              hbad_q, hbad_d;
  logic              line_end;
  logic              w_bad;

  assign line_end = blank_s2 & ~blank_s1;
  assign w_bad    = (pix_cnt_q != HCNT_W'(HDISP));

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    first_w_d  = first_w_q;
    line_cnt_d = line_cnt_q;
    hbad_d     = hbad_q;

    if (line_end)
      pix_cnt_d = '0;
    else if (blank_s1 && (pix_cnt_q != '1))
      pix_cnt_d = pix_cnt_q + 1'b1;

    // A line ending on the frame-boundary cycle opens the new frame.
    if (clear) begin
      line_cnt_d = VCNT_W'(line_end);
      first_w_d  = line_end ? pix_cnt_q : '0;
      hbad_d     = line_end & w_bad;
    end else if (line_end) begin
      if (line_cnt_q != '1)
        line_cnt_d = line_cnt_q + 1'b1;
      if (line_cnt_q == '0)
        first_w_d = pix_cnt_q;
      hbad_d = hbad_q | w_bad;
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      pix_cnt_q  <= '0;
      first_w_q  <= '0;
      line_cnt_q <= '0;
      hbad_q     <= 1'b0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      first_w_q  <= first_w_d;
      line_cnt_q <= line_cnt_d;
      hbad_q     <= hbad_d;
    end
  end

  assign first_w  = first_w_q;
  assign line_cnt = line_cnt_q;
  assign hbad     = hbad_q;

endmodule

// File: rtl/video_frame_checker.sv
// Rebuilds frame geometry from a sync/blank stream and checks it against HDISP x VDISP.
// Define FRAME_CHECKER_CSUM_EN to add the per-frame pixel checksum output frame_csum.
module video_frame_checker
  import video_chk_pkg::*;
#(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int HCNT_W      = HCNT_W_DEF,
  parameter int VCNT_W      = VCNT_W_DEF
) (
  input  logic                  pixel_clk,
  input  logic                  pixel_rst_n,
  video_frame_checker_if.slave  vid,
  output logic                  frame_done,
  output logic [HCNT_W-1:0]     meas_hdisp,
  output logic [VCNT_W-1:0]     meas_vdisp,
  output logic                  err_hsize,
  output logic                  err_vsize,
  output logic                  locked,
  output logic [15:0]           frame_cnt
`ifdef FRAME_CHECKER_CSUM_EN
  ,
  output logic [31:0]           frame_csum
`endif
);

  logic vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic blank_s1_q, blank_s1_d, blank_s2_q, blank_s2_d;
  logic vs_fall_q, vs_fall_d;

  chk_state_e             state_q, state_d;
  logic                   frame_done_q, frame_done_d;
  logic [HCNT_W-1:0]      meas_h_q, meas_h_d;
  logic [VCNT_W-1:0]      meas_v_q, meas_v_d;
  logic                   err_h_q, err_h_d;
  logic                   err_v_q, err_v_d;
  logic                   locked_q, locked_d;
  logic [LOCK_CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic [HCNT_W-1:0]      first_w;
  logic [VCNT_W-1:0]      line_cnt;
  logic                   hbad;
  logic                   vbad;
  logic                   frame_end;

  // Frame end is taken one cycle after the VS edge so a coincident line end is already counted.
  assign frame_end = vs_fall_q;
  assign vbad      = (line_cnt != VCNT_W'(VDISP));

  video_line_meter #(
    .HDISP  (HDISP),
    .HCNT_W (HCNT_W),
    .VCNT_W (VCNT_W)
  ) u_line_meter (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .blank_s1    (blank_s1_q),
    .blank_s2    (blank_s2_q),
    .clear       (frame_end),
    .first_w     (first_w),
    .line_cnt    (line_cnt),
    .hbad        (hbad)
  );

  always_comb begin
    vs_s1_d      = vid.vid_vs;
    vs_s2_d      = vs_s1_q;
    blank_s1_d   = vid.vid_blank;
    blank_s2_d   = blank_s1_q;
    vs_fall_d    = vs_s2_q & ~vs_s1_q;

    state_d      = state_q;
    frame_done_d = 1'b0;
    meas_h_d     = meas_h_q;
    meas_v_d     = meas_v_q;
    err_h_d      = err_h_q;
    err_v_d      = err_v_q;
    locked_d     = locked_q;
    good_cnt_d   = good_cnt_q;
    frame_cnt_d  = frame_cnt_q;

    if (frame_end) begin
      state_d = FRAME;
      if (state_q == FRAME) begin
        frame_done_d = 1'b1;
        meas_h_d     = first_w;
        meas_v_d     = line_cnt;
        err_h_d      = hbad;
        err_v_d      = vbad;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        if (hbad || vbad) begin
          good_cnt_d = '0;
          locked_d   = 1'b0;
        end else begin
          if (good_cnt_q != '1)
            good_cnt_d = good_cnt_q + 1'b1;
          locked_d = (good_cnt_d >= LOCK_CNT_W'(LOCK_FRAMES));
        end
      end
    end
  end

  // NOTE: state flops take non-blocking assignments so every flop sees the pre-edge values.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      blank_s1_q   <= 1'b0;
      blank_s2_q   <= 1'b0;
      vs_fall_q    <= 1'b0;
      state_q      <= WAIT_VS;
      frame_done_q <= 1'b0;
      meas_h_q     <= '0;
      meas_v_q     <= '0;
      err_h_q      <= 1'b0;
      err_v_q      <= 1'b0;
      locked_q     <= 1'b0;
      good_cnt_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      vs_s1_q      <= vs_s1_d;
      vs_s2_q      <= vs_s2_d;
      blank_s1_q   <= blank_s1_d;
      blank_s2_q   <= blank_s2_d;
      vs_fall_q    <= vs_fall_d;
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      meas_h_q     <= meas_h_d;
      meas_v_q     <= meas_v_d;
      err_h_q      <= err_h_d;
      err_v_q      <= err_v_d;
      locked_q     <= locked_d;
      good_cnt_q   <= good_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_done = frame_done_q;
  assign meas_hdisp = meas_h_q;
  assign meas_vdisp = meas_v_q;
  assign err_hsize  = err_h_q;
  assign err_vsize  = err_v_q;
  assign locked     = locked_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef FRAME_CHECKER_CSUM_EN
  logic [23:0] rgb_s1_q, rgb_s1_d;
  logic [31:0] csum_acc_q, csum_acc_d;
  logic [31:0] csum_q, csum_d;
  logic [31:0] pix_term;

  assign pix_term = blank_s1_q ? {8'h00, rgb_s1_q} : 32'h0;

  always_comb begin
    rgb_s1_d   = vid.vid_rgb;
    csum_acc_d = csum_acc_q + pix_term;
    csum_d     = csum_q;
    if (frame_end) begin
      csum_acc_d = pix_term;
      if (state_q == FRAME)
        csum_d = csum_acc_q;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      rgb_s1_q   <= '0;
      csum_acc_q <= '0;
      csum_q     <= '0;
    end else begin
      rgb_s1_q   <= rgb_s1_d;
      csum_acc_q <= csum_acc_d;
      csum_q     <= csum_d;
    end
  end

  assign frame_csum = csum_q;
`endif

endmodule

// File: tb/tb_video_frame_checker.sv
// Self-checking bench for video_frame_checker on a reduced 16x8 geometry.
module tb_video_frame_checker;

  localparam int HD = 16;
  localparam int VD = 8;
  localparam int LF = 2;
  localparam int HW = 12;
  localparam int VW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_frame_checker_if vif();

  logic          frame_done;
  logic [HW-1:0] meas_hdisp;
  logic [VW-1:0] meas_vdisp;
  logic          err_hsize;
  logic          err_vsize;
  logic          locked;
  logic [15:0]   frame_cnt;
`ifdef FRAME_CHECKER_CSUM_EN
  logic [31:0]   frame_csum;
`endif

  video_frame_checker #(
    .HDISP(HD), .VDISP(VD), .LOCK_FRAMES(LF), .HCNT_W(HW), .VCNT_W(VW)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .vid         (vif),
    .frame_done  (frame_done),
    .meas_hdisp  (meas_hdisp),
    .meas_vdisp  (meas_vdisp),
    .err_hsize   (err_hsize),
    .err_vsize   (err_vsize),
    .locked      (locked),
    .frame_cnt   (frame_cnt)
`ifdef FRAME_CHECKER_CSUM_EN
    ,
    .frame_csum  (frame_csum)
`endif
  );

  typedef struct {
    int nlines;
    int bad_line;
    int bad_w;
    bit merge;
    bit eh;
    bit ev;
    int mh;
    int mv;
    bit lock;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          eh;
    bit          ev;
    int          mh;
    int          mv;
    bit          lock;
    int          fcnt;
    logic [31:0] csum;
  } exp_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t pend;

  int          n_vec    = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_done   = 0;
  int          exp_fcnt = 0;
  bit          in_frame = 1'b0;
  logic [31:0] csum_acc = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_meas_hdisp"}, 32'(meas_hdisp), 0);
    check({tag, "_meas_vdisp"}, 32'(meas_vdisp), 0);
    check({tag, "_err_hsize"},  32'(err_hsize),  0);
    check({tag, "_err_vsize"},  32'(err_vsize),  0);
    check({tag, "_locked"},     32'(locked),     0);
    check({tag, "_frame_cnt"},  32'(frame_cnt),  0);
  endtask

  // Scoreboard: every frame_done pops one expected frame result.
  always @(negedge clk) begin : sb_check
    exp_t e;
    if (frame_done === 1'b1) begin
      n_done = n_done + 1;
      if (sb.size() == 0) begin
        check("spurious_frame_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency_cycle", 32'(cyc),        32'(e.cyc));
        check("meas_hdisp",    32'(meas_hdisp), 32'(e.mh));
        check("meas_vdisp",    32'(meas_vdisp), 32'(e.mv));
        check("err_hsize",     32'(err_hsize),  32'(e.eh));
        check("err_vsize",     32'(err_vsize),  32'(e.ev));
        check("locked",        32'(locked),     32'(e.lock));
        check("frame_cnt",     32'(frame_cnt),  32'(e.fcnt));
`ifdef FRAME_CHECKER_CSUM_EN
        check("frame_csum",    frame_csum,      e.csum);
`endif
      end
    end
  end

  task automatic drive(input bit vs, input bit blank, input bit hs, input logic [23:0] rgb);
    @(negedge clk);
    vif.vid_vs    = vs;
    vif.vid_blank = blank;
    vif.vid_hs    = hs;
    vif.vid_rgb   = rgb;
    if (blank) csum_acc = csum_acc + {8'h00, rgb};
  endtask

  task automatic vs_pulse();
    drive(1'b0, 1'b0, 1'b1, 24'h0);
    if (in_frame) begin
      exp_fcnt  = exp_fcnt + 1;
      pend.cyc  = cyc + 3;
      pend.fcnt = exp_fcnt;
      pend.csum = csum_acc;
      sb.push_back(pend);
    end
    in_frame = 1'b1;
    csum_acc = 32'h0;
    repeat (2)  drive(1'b0, 1'b0, 1'b1, 24'h0);
    repeat (10) drive(1'b1, 1'b0, 1'b1, 24'h0);
  endtask

  task automatic send_line(input int w, input bit merge);
    for (int i = 0; i < w; i++) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    if (!merge) begin
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      repeat (3) drive(1'b1, 1'b0, 1'b1, 24'h0);
    end
  endtask

  task automatic send_frame(input vec_t v);
    for (int l = 0; l < v.nlines; l++)
      send_line((l == v.bad_line) ? v.bad_w : HD, v.merge && (l == v.nlines - 1));
    if (!v.merge) repeat (3) drive(1'b1, 1'b0, 1'b1, 24'h0);
    pend.eh   = v.eh;
    pend.ev   = v.ev;
    pend.mh   = v.mh;
    pend.mv   = v.mv;
    pend.lock = v.lock;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d frame_done seen", n_done);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t g1;
    vec_t g2;
    //           lines bad  bw  mrg  eh ev  mh  mv lock
    vecs[0]  = '{8,   -1,  0,  0,   0, 0,  16, 8, 0};
    vecs[1]  = '{8,   -1,  0,  0,   0, 0,  16, 8, 1};
    vecs[2]  = '{8,   -1,  0,  0,   0, 0,  16, 8, 1};
    vecs[3]  = '{8,    5, 15,  0,   1, 0,  16, 8, 0};
    vecs[4]  = '{8,   -1,  0,  0,   0, 0,  16, 8, 0};
    vecs[5]  = '{8,   -1,  0,  0,   0, 0,  16, 8, 1};
    vecs[6]  = '{7,   -1,  0,  0,   0, 1,  16, 7, 0};
    vecs[7]  = '{9,   -1,  0,  0,   0, 1,  16, 9, 0};
    vecs[8]  = '{8,   -1,  0,  1,   0, 0,  16, 8, 0};
    vecs[9]  = '{8,   -1,  0,  0,   0, 0,  16, 8, 1};
    vecs[10] = '{8,    0, 17,  0,   1, 0,  17, 8, 0};
    vecs[11] = '{0,   -1,  0,  0,   0, 1,   0, 0, 0};
    vecs[12] = '{8,   -1,  0,  0,   0, 0,  16, 8, 0};
    g1       = '{8,   -1,  0,  0,   0, 0,  16, 8, 0};
    g2       = '{8,   -1,  0,  0,   0, 0,  16, 8, 1};

    vif.vid_vs    = 1'b1;
    vif.vid_blank = 1'b0;
    vif.vid_hs    = 1'b1;
    vif.vid_rgb   = 24'h0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    vs_pulse();
    for (int v = 0; v < NVEC; v++) begin
      send_frame(vecs[v]);
      vs_pulse();
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a frame: results vanish, first VS edge afterwards is silent.
    send_line(HD, 1'b0);
    send_line(HD, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n    = 1'b1;
    in_frame = 1'b0;
    exp_fcnt = 0;
    send_line(HD, 1'b0);
    send_line(HD, 1'b0);
    vs_pulse();
    send_frame(g1);
    vs_pulse();
    send_frame(g2);
    vs_pulse();
    repeat (5) @(negedge clk);
    check("scoreboard_final", 32'(sb.size()), 32'd0);
    check("frame_done_total", 32'(n_done), 32'(NVEC + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
